// File: rtl/div_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_sched_pkg
//  Description : Shared types and helpers for the divider scheduler.
//                Scheduler state encoding, requester IDs (which double as
//                the divider Select encoding) and the round-robin pick.
//  Revision    : 1.0 - initial release
// ============================================================================
package div_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        START = 2'd2,
        WAIT  = 2'd3
    } sched_state_t;

    // Requester IDs equal the divider Select value for that requester's operands.
    localparam logic REQ_SPEED = 1'b0;
    localparam logic REQ_AVG   = 1'b1;

    // Round-robin choice: with both pending, the one not served last wins.
    function automatic logic pick_grant(input logic pend_speed,
                                        input logic pend_avg,
                                        input logic last_grant);
        if (pend_speed && pend_avg) begin
            return ~last_grant;
        end else if (pend_avg) begin
            return REQ_AVG;
        end else begin
            return REQ_SPEED;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_scheduler_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : div_watchdog
//  Description : Saturating, clearable cycle counter used to abort a
//                division that never returns Ready.
//  Ports       : clock   - system clock
//                reset   - asynchronous active-high reset
//                clear   - synchronous clear to zero (priority over tick)
//                tick    - count one cycle
//                expired - count has reached TIMEOUT
//  Revision    : 1.0 - initial release
// ============================================================================
module div_watchdog
    import div_sched_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    localparam int                 c_cnt_w = $clog2(TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(TIMEOUT);

    logic [c_cnt_w-1:0] r_count;

    // Holds at the limit so a late check never sees a wrapped small value.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (tick && (r_count != c_limit)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign expired = (r_count == c_limit);

endmodule
`default_nettype wire

// File: rtl/div_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : div_scheduler
//  Description : Round-robin sequencer for the single shared divider.
//                Takes one-cycle requests from the speed and average-speed
//                paths, drives the divider Select/en, waits for Ready and
//                keeps the last quotient per requester. A watchdog aborts a
//                division that never completes.
//  Ports       : clock, reset          - clock, async active-high reset
//                req_speed, req_avg    - one-cycle request pulses
//                div_busy, div_ready   - divider Busy / Ready
//                div_res               - divider Res (valid with Ready)
//                div_select            - divider Select (0 speed, 1 avg)
//                div_enable            - divider en, one-cycle start pulse
//                res_speed, res_avg    - last captured quotient per requester
//                done_speed, done_avg  - one-cycle pulse, res_* updated
//                err_speed, err_avg    - one-cycle pulse, timeout abort
//                sched_busy            - high whenever not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module div_scheduler
    import div_sched_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_speed,
    input  logic             req_avg,
    input  logic             div_busy,
    input  logic             div_ready,
    input  logic [WIDTH-1:0] div_res,
    output logic             div_select,
    output logic             div_enable,
    output logic [WIDTH-1:0] res_speed,
    output logic [WIDTH-1:0] res_avg,
    output logic             done_speed,
    output logic             done_avg,
    output logic             err_speed,
    output logic             err_avg,
    output logic             sched_busy
);

    sched_state_t     r_state;
    logic             r_pend_speed;
    logic             r_pend_avg;
    logic             r_last_grant;
    logic             r_select;
    logic             r_enable;
    logic [WIDTH-1:0] r_res_speed;
    logic [WIDTH-1:0] r_res_avg;
    logic             r_done_speed;
    logic             r_done_avg;
    logic             r_err_speed;
    logic             r_err_avg;
    logic             r_busy;

    logic             w_grant_go;
    logic             w_grant_id;
    logic             w_expired;

    assign w_grant_go = (r_state == IDLE) && !div_busy && (r_pend_speed || r_pend_avg);
    assign w_grant_id = pick_grant(r_pend_speed, r_pend_avg, r_last_grant);

    div_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .clear   (r_state == START),
        .tick    (r_state == WAIT),
        .expired (w_expired)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_pend_speed <= 1'b0;
            r_pend_avg   <= 1'b0;
            r_last_grant <= REQ_AVG;
            r_select     <= REQ_SPEED;
            r_enable     <= 1'b0;
            r_res_speed  <= '0;
            r_res_avg    <= '0;
            r_done_speed <= 1'b0;
            r_done_avg   <= 1'b0;
            r_err_speed  <= 1'b0;
            r_err_avg    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            // A grant clears its pending bit, but a request in the same cycle
            // (including one from the requester being granted) still lands.
            r_pend_speed <= (r_pend_speed && !(w_grant_go && (w_grant_id == REQ_SPEED))) || req_speed;
            r_pend_avg   <= (r_pend_avg   && !(w_grant_go && (w_grant_id == REQ_AVG)))   || req_avg;

            r_enable     <= 1'b0;
            r_done_speed <= 1'b0;
            r_done_avg   <= 1'b0;
            r_err_speed  <= 1'b0;
            r_err_avg    <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_grant_go) begin
                        r_select     <= w_grant_id;
                        r_last_grant <= w_grant_id;
                        r_busy       <= 1'b1;
                        r_state      <= SETUP;
                    end
                end
                SETUP: begin
                    // Start pulse is registered here so it is high during START.
                    r_enable <= 1'b1;
                    r_state  <= START;
                end
                START: begin
                    r_state <= WAIT;
                end
                WAIT: begin
                    // Ready is checked first so a result arriving on the
                    // timeout cycle is still accepted without an error.
                    if (div_ready) begin
                        if (r_select == REQ_AVG) begin
                            r_res_avg  <= div_res;
                            r_done_avg <= 1'b1;
                        end else begin
                            r_res_speed  <= div_res;
                            r_done_speed <= 1'b1;
                        end
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else if (w_expired) begin
                        if (r_select == REQ_AVG) begin
                            r_err_avg <= 1'b1;
                        end else begin
                            r_err_speed <= 1'b1;
                        end
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign div_select = r_select;
    assign div_enable = r_enable;
    assign res_speed  = r_res_speed;
    assign res_avg    = r_res_avg;
    assign done_speed = r_done_speed;
    assign done_avg   = r_done_avg;
    assign err_speed  = r_err_speed;
    assign err_avg    = r_err_avg;
    assign sched_busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_div_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_scheduler
//  Description : Self-checking bench for div_scheduler. An emulated divider
//                answers each start pulse; a transaction-timing reference
//                model predicts every output each cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_div_scheduler;

    localparam int WIDTH   = 16;
    localparam int TIMEOUT = 20;

    logic             clock     = 1'b0;
    logic             reset     = 1'b1;
    logic             req_speed = 1'b0;
    logic             req_avg   = 1'b0;
    logic             div_busy  = 1'b0;
    logic             div_ready = 1'b0;
    logic [WIDTH-1:0] div_res   = '0;
    logic             div_select;
    logic             div_enable;
    logic [WIDTH-1:0] res_speed;
    logic [WIDTH-1:0] res_avg;
    logic             done_speed;
    logic             done_avg;
    logic             err_speed;
    logic             err_avg;
    logic             sched_busy;

    div_scheduler #(
        .WIDTH   (WIDTH),
        .TIMEOUT (TIMEOUT)
    ) u_dut (
        .clock      (clock),
        .reset      (reset),
        .req_speed  (req_speed),
        .req_avg    (req_avg),
        .div_busy   (div_busy),
        .div_ready  (div_ready),
        .div_res    (div_res),
        .div_select (div_select),
        .div_enable (div_enable),
        .res_speed  (res_speed),
        .res_avg    (res_avg),
        .done_speed (done_speed),
        .done_avg   (done_avg),
        .err_speed  (err_speed),
        .err_avg    (err_avg),
        .sched_busy (sched_busy)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    int edge_n   = 0;

    // Reference model: per-requester pending flags plus the edge of the
    // current grant; all output timing follows from that edge.
    bit               m_pend [2];
    bit               m_last, m_active, m_who, m_sel, m_en;
    bit               m_done [2];
    bit               m_err  [2];
    logic [WIDTH-1:0] m_res  [2];
    int               m_grant;

    // Divider emulation.
    int               dv_left = 0;
    bit               dv_hang = 1'b0;
    logic [WIDTH-1:0] dv_val  = '0;
    bit               rnd_div = 1'b0;
    int               cfg_lat = 10;
    bit               cfg_hang = 1'b0;
    logic [WIDTH-1:0] cfg_val_s = '0;
    logic [WIDTH-1:0] cfg_val_a = '0;

    // Observations for scenario-level checks.
    bit sel_log [$];
    int cnt_done_s, cnt_done_a, cnt_err_s, cnt_err_a;
    int t_en0, t_done_s, t_done_a, t_err_a;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed 0x%0h, expected 0x%0h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    function automatic void model_reset();
        m_pend   = '{1'b0, 1'b0};
        m_last   = 1'b1;
        m_active = 1'b0;
        m_who    = 1'b0;
        m_sel    = 1'b0;
        m_en     = 1'b0;
        m_done   = '{1'b0, 1'b0};
        m_err    = '{1'b0, 1'b0};
        m_res    = '{'0, '0};
        m_grant  = -100;
    endfunction

    function automatic void model_edge(input bit rs, input bit ra, input bit busy,
                                       input bit rdy, input logic [WIDTH-1:0] res);
        bit who;
        m_done = '{1'b0, 1'b0};
        m_err  = '{1'b0, 1'b0};
        if (!m_active) begin
            if (!busy && (m_pend[0] || m_pend[1])) begin
                if (m_pend[0] && m_pend[1]) who = !m_last;
                else                        who = m_pend[1];
                m_active     = 1'b1;
                m_who        = who;
                m_last       = who;
                m_sel        = who;
                m_grant      = edge_n;
                m_pend[who]  = 1'b0;
            end
        end else if (edge_n >= m_grant + 3) begin
            // Waiting for the divider: grant+2 is the edge that enters WAIT.
            if (rdy) begin
                m_res[m_who]  = res;
                m_done[m_who] = 1'b1;
                m_active      = 1'b0;
            end else if (edge_n == m_grant + 3 + TIMEOUT) begin
                m_err[m_who] = 1'b1;
                m_active     = 1'b0;
            end
        end
        if (rs) m_pend[0] = 1'b1;
        if (ra) m_pend[1] = 1'b1;
        m_en = m_active && (edge_n == m_grant + 1);
    endfunction

    task automatic clear_obs();
        sel_log.delete();
        cnt_done_s = 0; cnt_done_a = 0; cnt_err_s = 0; cnt_err_a = 0;
        t_en0 = -1; t_done_s = -1; t_done_a = -1; t_err_a = -1;
    endtask

    task automatic check_outputs();
        chk_eq("ctl{sel,en,busy,ds,da,es,ea}",
               {div_select, div_enable, sched_busy, done_speed, done_avg, err_speed, err_avg},
               {m_sel, m_en, m_active, m_done[0], m_done[1], m_err[0], m_err[1]});
        chk_eq("res_speed", res_speed, m_res[0]);
        chk_eq("res_avg",   res_avg,   m_res[1]);
        if (div_enable) begin
            sel_log.push_back(div_select);
            if (t_en0 < 0) t_en0 = edge_n;
        end
        if (done_speed) begin cnt_done_s++; if (t_done_s < 0) t_done_s = edge_n; end
        if (done_avg)   begin cnt_done_a++; if (t_done_a < 0) t_done_a = edge_n; end
        if (err_speed)  cnt_err_s++;
        if (err_avg)    begin cnt_err_a++; if (t_err_a < 0) t_err_a = edge_n; end
    endtask

    // One clock: called at a falling edge, drives inputs, advances the
    // model across the rising edge and checks at the next falling edge.
    task automatic step(input bit rs, input bit ra, input bit xb);
        if (div_enable) begin
            if (rnd_div) begin
                dv_left = $urandom_range(1, 12);
                dv_hang = ($urandom_range(0, 4) == 0);
                dv_val  = WIDTH'($urandom);
            end else begin
                dv_left = cfg_lat;
                dv_hang = cfg_hang;
                dv_val  = div_select ? cfg_val_a : cfg_val_s;
            end
        end
        req_speed = rs;
        req_avg   = ra;
        div_busy  = xb || (dv_left > 1);
        div_ready = (dv_left == 1) && !dv_hang;
        div_res   = div_ready ? dv_val : WIDTH'($urandom);
        if (dv_left > 0) dv_left--;
        @(posedge clock);
        edge_n++;
        if (reset) model_reset();
        else       model_edge(rs, ra, div_busy, div_ready, div_res);
        @(negedge clock);
        check_outputs();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs();
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        clear_obs();
    endtask

    initial begin
        int base;
        model_reset();
        clear_obs();
        @(negedge clock);
        do_reset();
        chk_eq("rst_select", div_select, 1'b0);
        chk_eq("rst_busy",   sched_busy, 1'b0);
        chk_eq("rst_res",    {res_speed, res_avg}, 32'h0);

        // Single uncontested speed request.
        cfg_lat = 10; cfg_hang = 1'b0; cfg_val_s = 16'h0123; cfg_val_a = 16'h0456;
        base = edge_n;
        step(1'b1, 1'b0, 1'b0);
        repeat (20) step(1'b0, 1'b0, 1'b0);
        chk_eq("t1_res_speed", res_speed, 16'h0123);
        chk_eq("t1_res_avg",   res_avg,   16'h0000);
        chk_eq("t1_done_cnt",  cnt_done_s, 1);
        chk_eq("t1_en_cnt",    sel_log.size(), 1);
        chk_eq("t1_en_edge",   t_en0 - base, 3);
        if (sel_log.size() >= 1) chk_eq("t1_sel", sel_log[0], 1'b0);

        // Simultaneous requests after reset: speed first, then avg.
        do_reset();
        cfg_lat = 6; cfg_val_s = 16'h1111; cfg_val_a = 16'h2222;
        step(1'b1, 1'b1, 1'b0);
        repeat (30) step(1'b0, 1'b0, 1'b0);
        chk_eq("t2_res_speed", res_speed, 16'h1111);
        chk_eq("t2_res_avg",   res_avg,   16'h2222);
        chk_eq("t2_grants",    sel_log.size(), 2);
        chk_eq("t2_order",     (t_done_s >= 0) && (t_done_s < t_done_a), 1);
        if (sel_log.size() >= 2) chk_eq("t2_second_sel", sel_log[1], 1'b1);

        // Both re-request on every completion: grants must alternate.
        do_reset();
        cfg_lat = 3;
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 300 && sel_log.size() < 12; i++) step(done_speed, done_avg, 1'b0);
        repeat (20) step(1'b0, 1'b0, 1'b0);
        chk_eq("t3_grants", sel_log.size() >= 12, 1);
        if (sel_log.size() >= 12) begin
            for (int i = 0; i < 12; i++) chk_eq("t3_alternate", sel_log[i], i % 2);
        end

        // Divider never answers avg; queued speed request is served after abort.
        do_reset();
        cfg_lat = 10; cfg_hang = 1'b1; cfg_val_s = 16'h3333;
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        repeat (8) step(1'b0, 1'b0, 1'b0);
        cfg_hang = 1'b0;
        repeat (40) step(1'b0, 1'b0, 1'b0);
        chk_eq("t4_err_avg_cnt",   cnt_err_a, 1);
        chk_eq("t4_err_speed_cnt", cnt_err_s, 0);
        chk_eq("t4_err_latency",   t_err_a - (t_en0 + 1), TIMEOUT + 1);
        chk_eq("t4_res_avg",       res_avg, 16'h0000);
        chk_eq("t4_res_speed",     res_speed, 16'h3333);
        chk_eq("t4_done_speed",    cnt_done_s, 1);

        // Divider busy for 8 cycles holds off the grant.
        do_reset();
        cfg_lat = 5; cfg_val_s = 16'h4444;
        base = edge_n;
        step(1'b1, 1'b0, 1'b1);
        repeat (7) step(1'b0, 1'b0, 1'b1);
        chk_eq("t5_no_enable", sel_log.size(), 0);
        repeat (15) step(1'b0, 1'b0, 1'b0);
        chk_eq("t5_en_edge",  t_en0 - base, 10);
        chk_eq("t5_res",      res_speed, 16'h4444);

        // Reset asserted mid-WAIT, divider answers afterwards.
        do_reset();
        cfg_lat = 12; cfg_val_a = 16'h5555;
        step(1'b0, 1'b1, 1'b0);
        repeat (6) step(1'b0, 1'b0, 1'b0);
        chk_eq("t6_in_service", sched_busy, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk_eq("t6_async_ctl", {div_select, div_enable, sched_busy, done_speed, done_avg,
                                err_speed, err_avg}, 7'h00);
        model_reset();
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        repeat (15) step(1'b0, 1'b0, 1'b0);
        chk_eq("t6_no_done", cnt_done_a + cnt_done_s, 0);
        chk_eq("t6_no_err",  cnt_err_a + cnt_err_s, 0);
        chk_eq("t6_res_avg", res_avg, 16'h0000);
        chk_eq("t6_grants",  sel_log.size(), 1);

        // Randomized traffic with a random divider, checked cycle by cycle.
        do_reset();
        rnd_div = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if (i == 750) do_reset();
            step($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0);
        end
        repeat (40) step(1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
